// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

    localparam int LANES  = 4;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/byte_bank.sv
// rtl/byte_bank.sv - one byte lane of data memory
// Purpose: DEPTH x 8 storage, synchronous write, combinational read, single address.
// Ports:
//   clk    clock
//   we     write enable for this lane
//   addr   word index shared by read and write
//   wdata  byte to store
//   rdata  byte currently stored at addr
module byte_bank #(
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with programmable wait states
// Purpose: accepts one request at a time, commits enabled byte lanes and
// returns a one-cycle response pulse after WAIT_STATES extra cycles.
// Ports:
//   clk, nrst         clock, synchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_addr          byte address, word index is req_addr[7:2]
//   req_wdata         store data, lane k = bits [8k+7:8k]
//   req_wr            byte-lane write enables, 0 = load
//   resp_valid        one-cycle response pulse
//   resp_rdata        merged word after the write (0 on error), held until next response
//   resp_err          misaligned or out-of-range request, held until next response
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [LANES-1:0]  req_wr,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       commit;

    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [LANES-1:0]  lat_wr;

    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [LANES-1:0]  cur_wr;
    logic              cur_err;
    logic [IW-1:0]     idx;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic [LANES-1:0]  lane_we;

    // With no wait states the commit edge is the acceptance edge itself, so
    // the banks must see the live request rather than the latch.
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_wr    = (state == IDLE) ? req_wr    : lat_wr;

    assign cur_err = (cur_addr[1:0] != 2'b00) ||
                     ({1'b0, cur_addr[7:2]} >= 7'(DEPTH));
    assign idx     = cur_addr[IW+1:2];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = nrst;
                if (req_valid && nrst) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wr     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (req_valid && req_ready) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wr    <= req_wr;
            end
            if (commit) begin
                resp_err   <= cur_err;
                resp_rdata <= cur_err ? 32'd0 : merged;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        // Reset on the commit edge wins, so the write is dropped.
        assign lane_we[k] = commit && nrst && !cur_err && cur_wr[k];
        assign merged[8*k +: 8] = cur_wr[k] ? cur_wdata[8*k +: 8] : old_word[8*k +: 8];

        byte_bank #(
            .DEPTH(DEPTH),
            .IW   (IW)
        ) u_bank (
            .clk  (clk),
            .we   (lane_we[k]),
            .addr (idx),
            .wdata(cur_wdata[8*k +: 8]),
            .rdata(old_word[8*k +: 8])
        );
    end

endmodule
